// File: rtl/nascom_video_timing_pkg.sv
// Shared timing constants for the NASCOM character display path.
// The RAM arbiter uses the same constants and the same vid_addr field split.
//   vid_addr = {mem_row[3:0] (bits MEM_ROW_MSB..COL_MSB+1), col[5:0] (bits COL_MSB..0)}
package nascom_video_timing_pkg;

  // Horizontal timing, in character periods of 8 pixel clocks.
  localparam int H_TOTAL     = 64;
  localparam int H_ACT_START = 10;
  localparam int H_ACT       = 48;
  localparam int HSYNC_START = 60;
  localparam int HSYNC_WIDTH = 4;

  // Vertical timing, in lines.
  localparam int V_TOTAL     = 312;
  localparam int V_ACT_START = 40;
  localparam int ROWS        = 16;
  localparam int ROW_LINES   = 14;
  localparam int VSYNC_START = 280;
  localparam int VSYNC_WIDTH = 4;

  // vid_addr field split.
  localparam int ADDR_W      = 10;
  localparam int MEM_ROW_MSB = 9;
  localparam int COL_MSB     = 5;

  // Control bits that travel through the one-character alignment delay.
  typedef struct packed {
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
  } video_ctl_t;

  // Inactive levels: blanked, no sync.
  localparam video_ctl_t CTL_IDLE = '{blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // The top text row on screen is held in the last 64-byte memory row, so
  // displayed row r lives in memory row r-1; row 0 wraps to 15 in 4 bits.
  function automatic logic [3:0] mem_row_of(input logic [3:0] row);
    return row - 4'd1;
  endfunction

endpackage

// File: rtl/nascom_video_timing_delay8.sv
// video_delay8: generic 8-stage shift delay with an asynchronous reset value.
// Ports:
//   clk   in  pixel clock
//   rst_n in  asynchronous active-low reset; every stage loads RST_VAL
//   d_i   in  W-bit input
//   q_o   out W-bit input delayed by 8 clocks
module video_delay8 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < 8; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[7];

endmodule

// File: rtl/nascom_video_timing.sv
// nascom_video_timing: character-mode video timing generator.
// Counts the pixel clock into pixel/char/line counters, derives the video RAM
// address, character-ROM scan line, shift-register load strobe, blanking and
// sync. All outputs are registered.
// Ports:
//   clk           in   pixel clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   vid_addr_o    out  video RAM address {mem_row[3:0], col[5:0]}, 0 outside active area
//   scan_o        out  character-ROM scan line within the text row
//   load_o        out  one-clock strobe: shift register loads ROM data
//   blank_n_o     out  high while visible pixels shift out
//   hsync_n_o     out  active-low horizontal sync
//   vsync_n_o     out  active-low vertical sync
//   frame_start_o out  one-clock pulse at the start of line 0
module nascom_video_timing
  import nascom_video_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_H_ACT_START = H_ACT_START,
  parameter int P_H_ACT       = H_ACT,
  parameter int P_HSYNC_START = HSYNC_START,
  parameter int P_HSYNC_WIDTH = HSYNC_WIDTH,
  parameter int V_TOTAL_P     = V_TOTAL,
  parameter int V_ACT_START_P = V_ACT_START,
  parameter int ROWS_P        = ROWS,
  parameter int ROW_LINES_P   = ROW_LINES,
  parameter int VSYNC_START_P = VSYNC_START,
  parameter int VSYNC_WIDTH_P = VSYNC_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] vid_addr_o,
  output logic [3:0]        scan_o,
  output logic              load_o,
  output logic              blank_n_o,
  output logic              hsync_n_o,
  output logic              vsync_n_o,
  output logic              frame_start_o
);

  // Illegal geometry is reported at elaboration and otherwise left as is.
  if (P_H_ACT_START + P_H_ACT > 64 || P_H_TOTAL > 64 || ROWS_P > 16 || ROW_LINES_P > 16 ||
      P_HSYNC_START + P_HSYNC_WIDTH > P_H_TOTAL || VSYNC_START_P + VSYNC_WIDTH_P > V_TOTAL_P ||
      V_ACT_START_P + ROWS_P * ROW_LINES_P > V_TOTAL_P || V_TOTAL_P > 512) begin : g_param_warn
    $warning("nascom_video_timing: illegal timing parameters");
  end

  // Counters.
  logic [2:0] pix_q,  pix_d;
  logic [5:0] chr_q,  chr_d;
  logic [8:0] line_q, line_d;
  logic [3:0] scan_cnt_q, scan_cnt_d;
  logic [3:0] row_q,  row_d;

  int chr_i, line_i, scan_i;
  assign chr_i  = int'(chr_q);
  assign line_i = int'(line_q);
  assign scan_i = int'(scan_cnt_q);

  logic act_line, act_chr, hsync_raw, vsync_raw;
  assign act_line  = (line_i >= V_ACT_START_P) && (line_i < V_ACT_START_P + ROWS_P * ROW_LINES_P);
  assign act_chr   = (chr_i >= P_H_ACT_START) && (chr_i < P_H_ACT_START + P_H_ACT);
  assign hsync_raw = (chr_i >= P_HSYNC_START) && (chr_i < P_HSYNC_START + P_HSYNC_WIDTH);
  assign vsync_raw = (line_i >= VSYNC_START_P) && (line_i < VSYNC_START_P + VSYNC_WIDTH_P);

  always_comb begin
    pix_d      = pix_q + 3'd1;
    chr_d      = chr_q;
    line_d     = line_q;
    scan_cnt_d = scan_cnt_q;
    row_d      = row_q;
    if (pix_q == 3'd7) begin
      if (chr_i == P_H_TOTAL - 1) begin
        chr_d = '0;
        if (line_i == V_TOTAL_P - 1) begin
          line_d     = '0;
          scan_cnt_d = '0;
          row_d      = '0;
        end else begin
          line_d = line_q + 9'd1;
          // Scan/row only step at the end of a displayed line.
          if (act_line) begin
            if (scan_i == ROW_LINES_P - 1) begin
              scan_cnt_d = '0;
              row_d      = row_q + 4'd1;
            end else begin
              scan_cnt_d = scan_cnt_q + 4'd1;
            end
          end
        end
      end else begin
        chr_d = chr_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q      <= '0;
      chr_q      <= '0;
      line_q     <= '0;
      scan_cnt_q <= '0;
      row_q      <= '0;
    end else begin
      pix_q      <= pix_d;
      chr_q      <= chr_d;
      line_q     <= line_d;
      scan_cnt_q <= scan_cnt_d;
      row_q      <= row_d;
    end
  end

  // Output stage: one register from the counters.
  logic [ADDR_W-1:0] vid_addr_d, vid_addr_q;
  logic [3:0]        scan_out_q;
  logic              load_d, load_q, frame_start_d, frame_start_q;
  video_ctl_t        ctl_d, ctl_q, ctl_dly;

  always_comb begin
    vid_addr_d    = '0;
    load_d        = 1'b0;
    frame_start_d = (line_q == 9'd0) && (chr_q == 6'd0) && (pix_q == 3'd0);
    ctl_d         = CTL_IDLE;
    if (act_line && act_chr) begin
      vid_addr_d[MEM_ROW_MSB:COL_MSB+1] = mem_row_of(row_q);
      vid_addr_d[COL_MSB:0]             = chr_q;
      load_d                            = (pix_q == 3'd7);
      ctl_d.blank_n                     = 1'b1;
    end
    ctl_d.hsync_n = ~hsync_raw;
    ctl_d.vsync_n = ~vsync_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_addr_q    <= '0;
      scan_out_q    <= '0;
      load_q        <= 1'b0;
      frame_start_q <= 1'b0;
      ctl_q         <= CTL_IDLE;
    end else begin
      vid_addr_q    <= vid_addr_d;
      scan_out_q    <= scan_cnt_q;
      load_q        <= load_d;
      frame_start_q <= frame_start_d;
      ctl_q         <= ctl_d;
    end
  end

  // Pixels of char N shift out during char N+1, so blank/sync trail the
  // address by one character period.
  video_delay8 #(
    .W       (3),
    .RST_VAL (CTL_IDLE)
  ) u_ctl_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ctl_q),
    .q_o   (ctl_dly)
  );

  assign vid_addr_o    = vid_addr_q;
  assign scan_o        = scan_out_q;
  assign load_o        = load_q;
  assign frame_start_o = frame_start_q;
  assign blank_n_o     = ctl_dly.blank_n;
  assign hsync_n_o     = ctl_dly.hsync_n;
  assign vsync_n_o     = ctl_dly.vsync_n;

endmodule

// File: tb/tb_nascom_video_timing.sv
// Bench for nascom_video_timing with a shortened vertical geometry:
// 58 lines/frame, active lines 2..49 (16 rows x 3 scan lines), vsync lines 52..55.
// Horizontal timing is the default 64 x 8 clk. "pos" is the counter state the
// registered outputs reflect: pos = edges since reset release - 1.
module tb_nascom_video_timing;

  localparam int TB_V_TOTAL = 58;
  localparam int FRAME      = TB_V_TOTAL * 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] vid_addr_o;
  logic [3:0] scan_o;
  logic       load_o, blank_n_o, hsync_n_o, vsync_n_o, frame_start_o;

  nascom_video_timing #(
    .V_TOTAL_P     (TB_V_TOTAL),
    .V_ACT_START_P (2),
    .ROWS_P        (16),
    .ROW_LINES_P   (3),
    .VSYNC_START_P (52),
    .VSYNC_WIDTH_P (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vid_addr_o    (vid_addr_o),
    .scan_o        (scan_o),
    .load_o        (load_o),
    .blank_n_o     (blank_n_o),
    .hsync_n_o     (hsync_n_o),
    .vsync_n_o     (vsync_n_o),
    .frame_start_o (frame_start_o)
  );

  // Clock / reset-relative edge counter.
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Scoreboard.
  typedef struct packed {
    logic [31:0] pos;
    logic [9:0]  addr;
    logic [3:0]  scan;
    logic        load;
    logic        blank_n;
    logic        hsync_n;
    logic        vsync_n;
    logic        frame_start;
  } vec_t;
  localparam int W = $bits(vec_t);
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int pos, input logic [9:0] addr, input logic [3:0] scan,
                      input logic ld, input logic bl, input logic hs, input logic vs,
                      input logic fs);
    vec_t v;
    v.pos = pos; v.addr = addr; v.scan = scan; v.load = ld;
    v.blank_n = bl; v.hsync_n = hs; v.vsync_n = vs; v.frame_start = fs;
    exp_q.push_back(v);
  endtask

  // Monitor: pops every expectation whose position has come up.
  int   pos;
  vec_t e;
  int   load_cnt = 0, blank_cnt = 0, hs_low_cnt = 0, fs_cnt = 0;
  int   fs_pos[2];

  always @(negedge clk) begin
    if (rst_n && edges > 0) begin
      pos = edges - 1;
      if (pos >= 1024 && pos < 1536) begin
        load_cnt   += int'(load_o);
        blank_cnt  += int'(blank_n_o);
        hs_low_cnt += int'(!hsync_n_o);
      end
      if (frame_start_o) begin
        if (fs_cnt < 2) fs_pos[fs_cnt] = pos;
        fs_cnt++;
      end
      while (exp_q.size() > 0) begin
        e = vec_t'(exp_q[0]);
        if (int'(e.pos) > pos) break;
        void'(exp_q.pop_front());
        if (int'(e.pos) < pos)
          check($sformatf("missed@%0d", e.pos), 32'(pos), e.pos);
        else
          check($sformatf("vec@%0d", pos),
                32'({vid_addr_o, scan_o, load_o, blank_n_o, hsync_n_o, vsync_n_o, frame_start_o}),
                32'({e.addr, e.scan, e.load, e.blank_n, e.hsync_n, e.vsync_n, e.frame_start}));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_vid_addr"}, 32'(vid_addr_o), 32'h0);
    check({tag, "_scan"}, 32'(scan_o), 32'h0);
    check({tag, "_load"}, 32'(load_o), 32'h0);
    check({tag, "_blank_n"}, 32'(blank_n_o), 32'h0);
    check({tag, "_hsync_n"}, 32'(hsync_n_o), 32'h1);
    check({tag, "_vsync_n"}, 32'(vsync_n_o), 32'h1);
    check({tag, "_frame_start"}, 32'(frame_start_o), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    //    pos    addr    scn ld bl hs vs fs
    push(0,      10'h0,   0, 0, 0, 1, 1, 1);
    push(1,      10'h0,   0, 0, 0, 1, 1, 0);
    push(88,     10'h0,   0, 0, 0, 1, 1, 0);
    push(487,    10'h0,   0, 0, 0, 1, 1, 0);
    push(488,    10'h0,   0, 0, 0, 0, 1, 0);
    push(519,    10'h0,   0, 0, 0, 0, 1, 0);
    push(520,    10'h0,   0, 0, 0, 1, 1, 0);
    push(1103,   10'h0,   0, 0, 0, 1, 1, 0);
    push(1104,   10'h3CA, 0, 0, 0, 1, 1, 0);
    push(1111,   10'h3CA, 0, 1, 0, 1, 1, 0);
    push(1112,   10'h3CB, 0, 0, 1, 1, 1, 0);
    push(1480,   10'h3F9, 0, 0, 1, 1, 1, 0);
    push(1487,   10'h3F9, 0, 1, 1, 1, 1, 0);
    push(1488,   10'h0,   0, 0, 1, 1, 1, 0);
    push(1495,   10'h0,   0, 0, 1, 1, 1, 0);
    push(1496,   10'h0,   0, 0, 0, 1, 1, 0);
    push(1616,   10'h3CA, 1, 0, 0, 1, 1, 0);
    push(2128,   10'h3CA, 2, 0, 0, 1, 1, 0);
    push(2640,   10'h00A, 0, 0, 0, 1, 1, 0);
    push(24144,  10'h38A, 0, 0, 0, 1, 1, 0);
    push(25168,  10'h38A, 2, 0, 0, 1, 1, 0);
    push(25176,  10'h38B, 2, 0, 1, 1, 1, 0);
    push(25680,  10'h0,   0, 0, 0, 1, 1, 0);
    push(25688,  10'h0,   0, 0, 0, 1, 1, 0);
    push(26631,  10'h0,   0, 0, 0, 0, 1, 0);
    push(26632,  10'h0,   0, 0, 0, 1, 0, 0);
    push(28679,  10'h0,   0, 0, 0, 0, 0, 0);
    push(28680,  10'h0,   0, 0, 0, 1, 1, 0);
    push(29695,  10'h0,   0, 0, 0, 0, 1, 0);
    push(29696,  10'h0,   0, 0, 0, 0, 1, 1);
    push(29704,  10'h0,   0, 0, 0, 1, 1, 0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (FRAME + 40) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_frame", 32'(exp_q.size()), 32'h0);
    check("load_count_line2", 32'(load_cnt), 32'd48);
    check("blank_clk_line2", 32'(blank_cnt), 32'd384);
    check("hsync_low_clk", 32'(hs_low_cnt), 32'd32);
    check("frame_start_count", 32'(fs_cnt), 32'd2);
    check("frame_length", 32'(fs_pos[1] - fs_pos[0]), 32'(FRAME));

    // Second frame, line 3 (row 0, scan 1), mid-line; then async reset.
    push(31432, 10'h3D9, 1, 0, 1, 1, 1, 0);
    push(31440, 10'h3DA, 1, 0, 1, 1, 1, 0);
    repeat (31441 - edges) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_midline", 32'(exp_q.size()), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async");

    repeat (3) @(posedge clk);
    push(0,    10'h0,   0, 0, 0, 1, 1, 1);
    push(88,   10'h0,   0, 0, 0, 1, 1, 0);
    push(488,  10'h0,   0, 0, 0, 0, 1, 0);
    push(1104, 10'h3CA, 0, 0, 0, 1, 1, 0);
    push(1112, 10'h3CB, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (1200) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_restart", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
